// File: rtl/bram_arbiter_if.sv
// bram_arbiter_if: requester-side bus of the two-port block-RAM arbiter
interface bram_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 16
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata
    );
endinterface

// File: rtl/bram_arbiter.sv
// bram_arbiter: zero-fills a block RAM after reset, then round-robin arbitrates two requesters onto it.
// Define BRAM_ARB_OREG_EN when the RAM output register is used (read latency 2 instead of 1).
module bram_arbiter #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic           clk,
    input  logic           resetn,
    bram_arbiter_if.slave  bus,
    output logic           init_done,
    output logic           mem_ce,
    output logic           mem_oce,
    output logic           mem_wre,
    output logic           mem_reset,
    output logic [AW-1:0]  mem_ad,
    output logic [DW-1:0]  mem_din,
    input  logic [DW-1:0]  mem_dout
);
`ifdef BRAM_ARB_OREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    typedef enum logic {INIT, RUN} state_t;

    state_t        state;
    state_t        next;
    logic [AW-1:0] init_addr;
    logic          last1;
    logic          run;
    logic          g0;
    logic          g1;
    logic [1:0]    rd_pipe [L];

    // State register: reset always restarts the clear pass
    always_ff @(posedge clk) begin
        state <= resetn ? next : INIT;
    end

    // Next state: leave INIT once the top address has been cleared
    always_comb begin
        next = (state == INIT && init_addr == '1) ? RUN : state;
    end

    // Outputs: clear writes in INIT, winner's access in RUN, idle bus otherwise
    always_comb begin
        run     = state == RUN && resetn;
        g0      = run && bus.req0 && (!bus.req1 || last1);
        g1      = run && bus.req1 && (!bus.req0 || !last1);
        mem_ce  = state == INIT || g0 || g1;
        mem_wre = state == INIT ? 1'b1 : g0 ? bus.we0 : g1 ? bus.we1 : 1'b0;
        mem_ad  = state == INIT ? init_addr : g0 ? bus.addr0 : g1 ? bus.addr1 : '0;
        mem_din = state == INIT ? '0 : g0 ? bus.wdata0 : g1 ? bus.wdata1 : '0;
    end

    assign bus.gnt0    = g0;
    assign bus.gnt1    = g1;
    assign bus.rvalid0 = resetn && rd_pipe[L-1][0];
    assign bus.rvalid1 = resetn && rd_pipe[L-1][1];
    assign bus.rdata   = mem_dout;
    assign mem_oce     = 1'b1;
    assign mem_reset   = !resetn;

    // Clear address walks upward in INIT and parks at zero otherwise
    always_ff @(posedge clk) begin
        init_addr <= (resetn && state == INIT) ? init_addr + 1'b1 : '0;
    end

    // Last-granted pointer moves only on a grant; reset leaves requester 0 favoured
    always_ff @(posedge clk) begin
        if (!resetn)
            last1 <= 1'b1;
        else if (g0 || g1)
            last1 <= g1;
    end

    // init_done rises together with entry into RUN
    always_ff @(posedge clk) begin
        init_done <= resetn && next == RUN;
    end

    // Read-owner pipeline: one-hot owner per granted read, aligned with RAM latency
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < L; i++)
                rd_pipe[i] <= 2'b00;
        end else begin
            rd_pipe[0] <= {g1 && !bus.we1, g0 && !bus.we0};
            for (int i = 1; i < L; i++)
                rd_pipe[i] <= rd_pipe[i-1];
        end
    end
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed scoreboard bench for bram_arbiter with a block-RAM model (AW=4)
module tb_bram_arbiter;
`ifdef BRAM_ARB_OREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    typedef struct {
        logic [15:0] d;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        init_done, mem_ce, mem_oce, mem_wre, mem_reset;
    logic [3:0]  mem_ad;
    logic [15:0] mem_din, mem_dout;
    logic [15:0] mem [16];
    logic [15:0] dq, dr;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [3:0]  a0 [3] = '{4'd5, 4'd7, 4'd3};
    logic [3:0]  a1 [3] = '{4'd3, 4'd5, 4'd7};

    bram_arbiter_if #(.AW(4), .DW(16)) bus();

    bram_arbiter #(.AW(4), .DW(16)) dut (
        .clk(clk), .resetn(resetn), .bus(bus), .init_done(init_done),
        .mem_ce(mem_ce), .mem_oce(mem_oce), .mem_wre(mem_wre), .mem_reset(mem_reset),
        .mem_ad(mem_ad), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Block RAM: registered read, optional output register
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_wre) mem[mem_ad] <= mem_din;
            else dq <= mem[mem_ad];
        end
        if (mem_oce) dr <= dq;
    end
`ifdef BRAM_ARB_OREG_EN
    assign mem_dout = dr;
`else
    assign mem_dout = dq;
`endif

    // Monitor: any rvalid, or any cycle a read is due, is checked against the scoreboard
    always @(negedge clk) begin
        logic        e;
        logic [15:0] d;
        e = q0.size() > 0 && q0[0].c == cyc;
        d = e ? q0[0].d : 16'h0;
        if (bus.rvalid0 || e) begin
            checks++;
            if (!(bus.rvalid0 && e && bus.rdata == d)) begin
                errors++;
                $display("FAIL rvalid0 cyc %0d: got v=%0b d=%h want v=%0b d=%h", cyc, bus.rvalid0, bus.rdata, e, d);
            end
            if (e) void'(q0.pop_front());
        end
        e = q1.size() > 0 && q1[0].c == cyc;
        d = e ? q1[0].d : 16'h0;
        if (bus.rvalid1 || e) begin
            checks++;
            if (!(bus.rvalid1 && e && bus.rdata == d)) begin
                errors++;
                $display("FAIL rvalid1 cyc %0d: got v=%0b d=%h want v=%0b d=%h", cyc, bus.rvalid1, bus.rdata, e, d);
            end
            if (e) void'(q1.pop_front());
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cyc %0d: got %h want %h", n, cyc, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] dat(input logic [3:0] a);
        return a == 4'd5 ? 16'hA5A5 : a == 4'd7 ? 16'h0707 : 16'h1234;
    endfunction

    task automatic init_walk();
        for (int i = 0; i < 16; i++) begin
            chk("init_ad", 32'(mem_ad), i);
            chk("init_ctl", {29'd0, mem_ce, mem_wre, init_done}, 'b110);
            chk("init_din", 32'(mem_din), 0);
            chk("init_gnt", {30'd0, bus.gnt0, bus.gnt1}, 0);
            tick();
            #1;
        end
    endtask

    initial begin
        int i0 = 0;
        int i1 = 0;
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        repeat (3) tick();
        #1;
        chk("rst_done", {29'd0, init_done, bus.rvalid0, bus.rvalid1}, 0);
        chk("rst_memrst", {30'd0, mem_reset, mem_oce}, 'b11);
        tick();
        resetn = 1;
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 4'd7; bus.wdata0 = 16'h0707;
        #1;
        init_walk();
        chk("run_done", 32'(init_done), 1);
        chk("held_gnt0", 32'(bus.gnt0), 1);
        chk("held_ad", {11'd0, mem_wre, mem_ad, mem_din}, {11'd0, 1'b1, 4'd7, 16'h0707});
        tick();
        bus.addr0 = 4'd5; bus.wdata0 = 16'hA5A5;
        #1;
        chk("wr5", {11'd0, bus.gnt0, mem_ad, mem_din}, {11'd0, 1'b1, 4'd5, 16'hA5A5});
        tick();
        bus.we0 = 0;
        #1;
        chk("rd5", {26'd0, bus.gnt0, mem_wre, mem_ad}, {26'd0, 1'b1, 1'b0, 4'd5});
        q0.push_back('{16'hA5A5, cyc + L});
        tick();
        bus.req0 = 0;
        #1;
        chk("idle", {10'd0, mem_ce, bus.gnt0, mem_ad, mem_din}, 0);
        tick();
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 4'd3; bus.wdata1 = 16'h1234;
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 4'd3;
        #1;
        chk("coll_gnt", {30'd0, bus.gnt0, bus.gnt1}, 'b01);
        chk("coll_din", {12'd0, mem_ad, mem_din}, {12'd0, 4'd3, 16'h1234});
        tick();
        bus.req1 = 0;
        #1;
        chk("coll_rd", {30'd0, bus.gnt0, bus.gnt1}, 'b10);
        q0.push_back('{16'h1234, cyc + L});
        tick();
        bus.req0 = 0; bus.req1 = 1; bus.we1 = 0; bus.addr1 = 4'd7;
        #1;
        chk("pre_gnt1", 32'(bus.gnt1), 1);
        q1.push_back('{16'h0707, cyc + L});
        for (int k = 0; k < 6; k++) begin
            tick();
            bus.req0 = 1; bus.req1 = 1; bus.addr0 = a0[i0]; bus.addr1 = a1[i1];
            #1;
            chk("alt_gnt", {30'd0, bus.gnt0, bus.gnt1}, (k % 2 == 0) ? 'b10 : 'b01);
            if (k % 2 == 0) begin
                q0.push_back('{dat(a0[i0]), cyc + L});
                i0++;
            end else begin
                q1.push_back('{dat(a1[i1]), cyc + L});
                i1++;
            end
        end
        tick();
        bus.req0 = 0; bus.req1 = 0;
        repeat (L + 2) tick();
        chk("drain", 32'(q0.size() + q1.size()), 0);
        bus.req0 = 1; bus.addr0 = 4'd5;
        #1;
        chk("pre_rst_gnt", 32'(bus.gnt0), 1);
        tick();
        resetn = 0;
        #1;
        chk("rst_gnt", {30'd0, bus.gnt0, mem_reset}, 'b01);
        repeat (3) begin
            tick();
            #1;
            chk("rst_rv", {29'd0, init_done, bus.rvalid0, bus.rvalid1}, 0);
        end
        tick();
        resetn = 1; bus.req0 = 0;
        #1;
        init_walk();
        chk("rerun_done", 32'(init_done), 1);
        repeat (L + 2) tick();
        chk("end_q", 32'(q0.size() + q1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
